// File: rtl/risc_v_pkg.sv
// Shared types and defaults for the data-memory responder.
// Holds the responder FSM state encoding and the address check helper.
package risc_v_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_rsp_state_e;

    localparam int MEM_LAT_DEFAULT   = 2;
    localparam int MEM_DEPTH_DEFAULT = 256;

    // Misaligned word access or word index past the end of storage.
    function automatic logic mem_addr_err(
        input logic [31:0] addr,
        input int unsigned depth
    );
        logic [31:0] widx;
        widx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (widx >= depth);
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port word storage: synchronous byte-enabled write,
// combinational read. Contents start at zero and survive reset.
module data_mem_array
    import risc_v_pkg::*;
#(
    parameter int DEPTH_WORDS = MEM_DEPTH_DEFAULT
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    input  logic [3:0]                     be,
    output logic [31:0]                    rdata
);

    logic [31:0] mem_q [DEPTH_WORDS] = '{default: 32'h0};

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one request, waits LATENCY cycles,
// then performs the access and holds the response until taken.
module data_mem_responder
    import risc_v_pkg::*;
#(
    parameter int DEPTH_WORDS = MEM_DEPTH_DEFAULT,
    parameter int LATENCY     = MEM_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 =
        (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    mem_rsp_state_e state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           we_q, we_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [3:0]     be_q, be_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;

    logic           enter_resp;
    logic           cur_we;
    logic [31:0]    cur_addr;
    logic [31:0]    cur_wdata;
    logic [3:0]     cur_be;
    logic           cur_err;
    logic           mem_we;
    logic [31:0]    mem_rdata;

    // With zero latency the access happens on the accept edge,
    // so the raw request is used before it has been latched.
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_be    = be_q;
        if (state_q == IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end
        cur_err = mem_addr_err(cur_addr, DEPTH_WORDS);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        mem_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_resp) begin
            err_d   = cur_err;
            rdata_d = (!cur_we && !cur_err) ? mem_rdata : 32'h0;
            mem_we  = cur_we && !cur_err && !srst;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    data_mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (cur_addr[AW+1:2]),
        .wdata (cur_wdata),
        .be    (cur_be),
        .rdata (mem_rdata)
    );

    assign req_ready = (state_q == IDLE) && !srst;
    assign rsp_valid = (state_q == RESP) && !srst;
    assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
    assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY 2 and LATENCY 0.
// Each test task drives one scenario and checks its own results.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        srst = 1'b1;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_be = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        req_valid0 = 1'b0;
    logic        req_ready0;
    logic        req_we0 = 1'b0;
    logic [31:0] req_addr0 = 32'h0;
    logic [31:0] req_wdata0 = 32'h0;
    logic [3:0]  req_be0 = 4'h0;
    logic        rsp_valid0;
    logic        rsp_ready0 = 1'b0;
    logic [31:0] rsp_rdata0;
    logic        rsp_err0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk(clk), .srst(srst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
        .clk(clk), .srst(srst),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we0), .req_addr(req_addr0),
        .req_wdata(req_wdata0), .req_be(req_be0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    // Present a request, let it be accepted, return at the first
    // negedge showing rsp_valid; lat = cycles from accept edge.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_ready_timeout addr=%h got req_ready=%b want 1",
                     addr, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic complete();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_req_ready got %b want 0", req_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_rsp_valid got %b want 0", rsp_valid);
        end
        checks++;
        if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_rsp_data got %h/%b want 0/0",
                     rsp_rdata, rsp_err);
        end
        srst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_store_load();
        int lat;
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL st_latency got %0d want 3", lat);
        end
        checks++;
        if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL st_rsp got %h/%b want 0/0", rsp_rdata, rsp_err);
        end
        complete();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL st_done got rdy=%b vld=%b want 1/0",
                     req_ready, rsp_valid);
        end
        issue(1'b0, 32'h10, 32'h0, 4'h0, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL ld_latency got %0d want 3", lat);
        end
        checks++;
        if (rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL ld_rsp got %h/%b want deadbeef/0",
                     rsp_rdata, rsp_err);
        end
        complete();
    endtask

    task automatic test_byte_enable();
        int lat;
        issue(1'b1, 32'h20, 32'h11223344, 4'hF, lat);
        complete();
        issue(1'b1, 32'h20, 32'h0000AA00, 4'h2, lat);
        complete();
        issue(1'b0, 32'h20, 32'h0, 4'h0, lat);
        checks++;
        if (rsp_rdata !== 32'h1122AA44 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL be_partial got %h/%b want 1122aa44/0",
                     rsp_rdata, rsp_err);
        end
        complete();
        issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, lat);
        checks++;
        if (lat !== 3 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL be_zero_rsp got lat=%0d %h/%b want 3 0/0",
                     lat, rsp_rdata, rsp_err);
        end
        complete();
        issue(1'b0, 32'h20, 32'h0, 4'h0, lat);
        checks++;
        if (rsp_rdata !== 32'h1122AA44) begin
            errors++;
            $display("FAIL be_zero_mem got %h want 1122aa44", rsp_rdata);
        end
        complete();
    endtask

    task automatic test_errors();
        int lat;
        issue(1'b0, 32'h13, 32'h0, 4'h0, lat);
        checks++;
        if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL err_misalign got %b/%h want 1/0",
                     rsp_err, rsp_rdata);
        end
        complete();
        issue(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, lat);
        checks++;
        if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL err_range got %b/%h want 1/0",
                     rsp_err, rsp_rdata);
        end
        complete();
        issue(1'b0, 32'h0, 32'h0, 4'h0, lat);
        checks++;
        if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL err_no_write got %b/%h want 0/0",
                     rsp_err, rsp_rdata);
        end
        complete();
        issue(1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hF, lat);
        checks++;
        if (rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL err_last_word got %b want 0", rsp_err);
        end
        complete();
        issue(1'b0, 32'h3FC, 32'h0, 4'h0, lat);
        checks++;
        if (rsp_rdata !== 32'hA5A5A5A5 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL err_last_load got %h/%b want a5a5a5a5/0",
                     rsp_rdata, rsp_err);
        end
        complete();
    endtask

    task automatic test_hold();
        int lat;
        issue(1'b0, 32'h10, 32'h0, 4'h0, lat);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'hFFFFFFFF;
        req_be    = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF ||
                rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable c%0d got %b %h %b want 1 deadbeef 0",
                         i, rsp_valid, rsp_rdata, rsp_err);
            end
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_ready c%0d got %b want 0", i, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_complete got vld=%b rdy=%b want 0/1",
                     rsp_valid, req_ready);
        end
        issue(1'b0, 32'h30, 32'h0, 4'h0, lat);
        checks++;
        if (rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL hold_ignored_req got %h want 0", rsp_rdata);
        end
        complete();
    endtask

    task automatic test_reset_abort();
        int lat;
        bit seen;
        issue(1'b1, 32'h8, 32'h12345678, 4'hF, lat);
        complete();
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h8;
        req_wdata = 32'hCAFEF00D;
        req_be    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        srst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_rst got vld=%b rdy=%b want 0/0",
                     rsp_valid, req_ready);
        end
        srst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready got %b want 1", req_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_rsp got %b want 0", seen);
        end
        issue(1'b0, 32'h8, 32'h0, 4'h0, lat);
        checks++;
        if (rsp_rdata !== 32'h12345678 || lat !== 3) begin
            errors++;
            $display("FAIL abort_mem got %h lat=%0d want 12345678 3",
                     rsp_rdata, lat);
        end
        complete();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_valid0 = 1'b1;
        req_we0    = 1'b1;
        req_addr0  = 32'h4;
        req_wdata0 = 32'h55AA55AA;
        req_be0    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid0 = 1'b0;
        checks++;
        if (rsp_valid0 !== 1'b1 || rsp_err0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_store got vld=%b err=%b want 1/0",
                     rsp_valid0, rsp_err0);
        end
        rsp_ready0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid0 = 1'b1;
        req_we0    = 1'b0;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if ((req_valid0 && req_ready0) !== (c % 2 == 0)) begin
                errors++;
                $display("FAIL b2b_accept c%0d got %b want %b", c,
                         req_ready0, (c % 2 == 0));
            end
            checks++;
            if (rsp_valid0 !== (c % 2 == 1)) begin
                errors++;
                $display("FAIL b2b_valid c%0d got %b want %b", c,
                         rsp_valid0, (c % 2 == 1));
            end
            if (c % 2 == 1) begin
                checks++;
                if (rsp_rdata0 !== 32'h55AA55AA || rsp_err0 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_data c%0d got %h/%b want 55aa55aa/0",
                             c, rsp_rdata0, rsp_err0);
                end
            end
            @(negedge clk);
        end
        req_valid0 = 1'b0;
        @(negedge clk);
        rsp_ready0 = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_hold();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
